// File: rtl/survivor_traceback.sv
// Survivor-memory traceback for a 4-state Viterbi decoder: stores one survivor
// entry per trellis step and, once the window is full, traces back to emit one bit.
module survivor_traceback #(
    parameter int TB_DEPTH = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       clr,
    input  logic       valid_in,
    output logic       ready_out,
    input  logic [1:0] addr_0,
    input  logic [1:0] addr_1,
    input  logic [1:0] addr_2,
    input  logic [1:0] addr_3,
    input  logic [6:0] pm_0,
    input  logic [6:0] pm_1,
    input  logic [6:0] pm_2,
    input  logic [6:0] pm_3,
    output logic       bit_out,
    output logic       bit_valid
);

    localparam int PW = $clog2(TB_DEPTH);
    localparam logic [PW-1:0] CNT_MAX   = PW'(TB_DEPTH - 1);
    localparam logic [PW-1:0] STEP_LAST = PW'(TB_DEPTH - 2);

    typedef enum logic [1:0] {IDLE, TRACE, OUT} state_t;

    state_t          r_state;
    logic [7:0]      r_mem [TB_DEPTH];
    logic [PW-1:0]   r_wr_ptr;
    logic [PW-1:0]   r_rd_ptr;
    logic [PW-1:0]   r_cnt;
    logic [PW-1:0]   r_step;
    logic [1:0]      r_cur_state;
    logic            r_bit_out;
    logic            r_bit_valid;

    logic            w_accept;
    logic [7:0]      w_wr_data;
    logic [7:0]      w_rd_entry;
    logic [1:0]      w_field [4];
    logic [1:0]      w_next_state;
    logic [1:0]      w_best_lo;
    logic [1:0]      w_best_hi;
    logic [6:0]      w_min_lo;
    logic [6:0]      w_min_hi;
    logic [1:0]      w_best;

    assign ready_out  = (r_state == IDLE);
    assign w_accept   = valid_in & ready_out;
    assign w_wr_data  = {addr_3, addr_2, addr_1, addr_0};
    assign bit_out    = r_bit_out;
    assign bit_valid  = r_bit_valid;

    // Strict less-than at every stage so ties resolve to the lowest state index.
    assign w_best_lo = (pm_1 < pm_0) ? 2'd1 : 2'd0;
    assign w_min_lo  = (pm_1 < pm_0) ? pm_1 : pm_0;
    assign w_best_hi = (pm_3 < pm_2) ? 2'd3 : 2'd2;
    assign w_min_hi  = (pm_3 < pm_2) ? pm_3 : pm_2;
    assign w_best    = (w_min_hi < w_min_lo) ? w_best_hi : w_best_lo;

    assign w_rd_entry = r_mem[r_rd_ptr];

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_field
            assign w_field[gi] = w_rd_entry[2*gi +: 2];
        end
    endgenerate

    assign w_next_state = w_field[r_cur_state];

    // Survivor storage has no reset; stale contents are never traced before refill.
    always_ff @(posedge clk) begin
        if (w_accept && !clr) begin
            r_mem[r_wr_ptr] <= w_wr_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_cnt       <= '0;
            r_step      <= '0;
            r_cur_state <= 2'b00;
            r_bit_out   <= 1'b0;
            r_bit_valid <= 1'b0;
        end else if (clr) begin
            r_state     <= IDLE;
            r_wr_ptr    <= '0;
            r_cnt       <= '0;
            r_bit_valid <= 1'b0;
        end else begin
            r_bit_valid <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (valid_in) begin
                        r_wr_ptr <= r_wr_ptr + PW'(1);
                        if (r_cnt != CNT_MAX) begin
                            r_cnt <= r_cnt + PW'(1);
                        end else begin
                            r_cur_state <= w_best;
                            r_rd_ptr    <= r_wr_ptr;
                            r_step      <= '0;
                            r_state     <= TRACE;
                        end
                    end
                end
                TRACE: begin
                    r_cur_state <= w_next_state;
                    r_rd_ptr    <= r_rd_ptr - PW'(1);
                    r_step      <= r_step + PW'(1);
                    if (r_step == STEP_LAST) begin
                        r_state <= OUT;
                    end
                end
                OUT: begin
                    r_bit_out   <= r_cur_state[1];
                    r_bit_valid <= 1'b1;
                    r_state     <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule
